// File: rtl/rv32i_store_unit.sv
// RV32I store path: decodes SB/SH/SW, picks a byte-lane memory region and emits
// registered lane-aligned beats; word-crossing stores are split into two beats.
module rv32i_store_unit #(
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'h0000C000, 32'h00008000},
    parameter logic [NUM_REGIONS*8-1:0]  REGION_BITS = {8'd13, 8'd14}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    output logic [4*NUM_REGIONS-1:0] mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     store_done,
    output logic                     store_fault,
    output logic                     busy
);

    typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

    state_t                   state, state_next;
    logic [31:0]              word_a, word_b, rot;
    logic [5:0]               rot_sh;
    logic [3:0]               size_lanes;
    logic                     size_ok;
    logic [7:0]               lanes;
    logic                     split, legal;
    logic [NUM_REGIONS-1:0]   hit_a, hit_b;
    logic [2:0]               idx_a, idx_b;

    logic [4*NUM_REGIONS-1:0] we_d, b1_we;
    logic [31:0]              addr_d, wdata_d, b1_addr, b1_data;
    logic                     done_d, fault_d, load_b1;

    function automatic logic [31:0] lane_mask(input logic [3:0] l);
        return {{8{l[3]}}, {8{l[2]}}, {8{l[1]}}, {8{l[0]}}};
    endfunction

    function automatic logic [4*NUM_REGIONS-1:0] region_we(input logic [2:0] idx,
                                                           input logic [3:0] l);
        logic [4*NUM_REGIONS-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_REGIONS; r++)
            if (idx == 3'(r)) v[4*r +: 4] = l;
        return v;
    endfunction

    assign word_a = {req_addr[31:2], 2'b00};
    assign word_b = word_a + 32'd4;
    assign rot_sh = {1'b0, req_addr[1:0], 3'b000};
    // A zero rotate shifts right by 32, which yields 0 and leaves the data intact.
    assign rot    = (req_data << rot_sh) | (req_data >> (6'd32 - rot_sh));

    always_comb begin
        size_lanes = 4'b0000;
        size_ok    = 1'b1;
        case (req_funct3)
            3'b000:  size_lanes = 4'b0001;
            3'b001:  size_lanes = 4'b0011;
            3'b010:  size_lanes = 4'b1111;
            default: size_ok    = 1'b0;
        endcase
    end

    // Lanes 4..7 spill into the next word; rotation already places them on lanes 0..3.
    assign lanes = {4'b0000, size_lanes} << req_addr[1:0];
    assign split = |lanes[7:4];

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        localparam int          SHIFT = int'(REGION_BITS[8*r +: 8]);
        localparam logic [31:0] BASE  = REGION_BASE[32*r +: 32];
        assign hit_a[r] = (word_a >> SHIFT) == (BASE >> SHIFT);
        assign hit_b[r] = (word_b >> SHIFT) == (BASE >> SHIFT);
    end

    always_comb begin
        idx_a = '0;
        idx_b = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (hit_a[r]) idx_a = 3'(r);
            if (hit_b[r]) idx_b = 3'(r);
        end
    end

    assign legal     = size_ok && (|hit_a) && (!split || (|hit_b));
    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state == SPLIT);

    always_comb begin
        state_next = state;
        we_d       = '0;
        addr_d     = '0;
        wdata_d    = '0;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        load_b1    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        we_d    = region_we(idx_a, lanes[3:0]);
                        addr_d  = word_a;
                        wdata_d = rot & lane_mask(lanes[3:0]);
                        if (split) begin
                            state_next = SPLIT;
                            load_b1    = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            SPLIT: begin
                we_d       = b1_we;
                addr_d     = b1_addr;
                wdata_d    = b1_data;
                done_d     = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_we      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            store_done  <= 1'b0;
            store_fault <= 1'b0;
        end else begin
            state       <= state_next;
            mem_we      <= we_d;
            mem_addr    <= addr_d;
            mem_wdata   <= wdata_d;
            store_done  <= done_d;
            store_fault <= fault_d;
        end
    end

    // Second-beat holding registers, captured when a split store is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            b1_we   <= '0;
            b1_addr <= '0;
            b1_data <= '0;
        end else if (load_b1) begin
            b1_we   <= region_we(idx_b, lanes[7:4]);
            b1_addr <= word_b;
            b1_data <= rot & lane_mask(lanes[7:4]);
        end
    end

endmodule

// File: tb/tb_rv32i_store_unit.sv
// Directed bench for rv32i_store_unit with default regions:
// region 0 = 0x8000..0xBFFF, region 1 = 0xC000..0xDFFF.
module tb_rv32i_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        store_done;
    logic        store_fault;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // {busy, req_ready, store_fault, store_done, mem_we, mem_addr, mem_wdata}
    logic [75:0] obs;
    assign obs = {busy, req_ready, store_fault, store_done, mem_we, mem_addr, mem_wdata};

    rv32i_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .store_done (store_done),
        .store_fault(store_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic set_req(input logic v, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_funct3 = f3;
        req_addr   = a;
        req_data   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [75:0] exp;
        reset = 1'b1;
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
    endtask

    task automatic test_sw();
        logic [75:0] exp;
        set_req(1'b1, 3'b010, 32'h00008004, 32'hDEADBEEF);
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 32'h00008004, 32'hDEADBEEF};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw_aligned got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL idle_after_sw got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [75:0] exp;
        set_req(1'b1, 3'b000, 32'h0000C003, 32'h123456AB);
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 32'h0000C000, 32'hAB000000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sb_region1 got=%h exp=%h", obs, exp); end
        set_req(1'b1, 3'b000, 32'h00008000, 32'h9999995A);
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 32'h00008000, 32'h0000005A};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sb_lane0 got=%h exp=%h", obs, exp); end
        set_req(1'b1, 3'b001, 32'h0000C002, 32'h7777BEEF);
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'hC0, 32'h0000C000, 32'hBEEF0000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sh_o2_nosplit got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_split();
        logic [75:0] exp;
        set_req(1'b1, 3'b001, 32'h00008003, 32'h00001234);
        tick();
        // Request held while not ready must wait for the beat-1 cycle.
        set_req(1'b1, 3'b010, 32'h00008010, 32'hCAFEF00D);
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 32'h00008000, 32'h34000000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sh_split_beat0 got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 32'h00008004, 32'h00000012};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sh_split_beat1 got=%h exp=%h", obs, exp); end
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 32'h00008010, 32'hCAFEF00D};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL held_after_split got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_cross_region();
        logic [75:0] exp;
        set_req(1'b1, 3'b010, 32'h0000BFFE, 32'h11223344);
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h0C, 32'h0000BFFC, 32'h33440000};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cross_beat0 got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 32'h0000C000, 32'h00001122};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL cross_beat1 got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_illegal();
        logic [75:0] exp;
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h0, 32'h0};
        set_req(1'b1, 3'b011, 32'h00008000, 32'h11111111);
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bad_funct3 got=%h exp=%h", obs, exp); end
        set_req(1'b1, 3'b010, 32'h00001000, 32'h22222222);
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL no_region got=%h exp=%h", obs, exp); end
        set_req(1'b1, 3'b010, 32'h0000DFFE, 32'h33333333);
        tick();
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL split_out_of_region got=%h exp=%h", obs, exp); end
        set_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h44444444);
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL wrap_split got=%h exp=%h", obs, exp); end
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL fault_one_cycle got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_reset_in_split();
        logic [75:0] exp;
        set_req(1'b1, 3'b001, 32'h00008003, 32'h00001234);
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL split_entered got=%b exp=1", busy); end
        reset = 1'b1;
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_in_split got=%h exp=%h", obs, exp); end
        reset = 1'b0;
        tick();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL no_beat1_after_reset got=%h exp=%h", obs, exp); end
        set_req(1'b1, 3'b010, 32'h00008004, 32'hDEADBEEF);
        tick();
        set_req(1'b0, 3'b000, 32'h0, 32'h0);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 32'h00008004, 32'hDEADBEEF};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw_after_reset got=%h exp=%h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_back_to_back();
        test_split();
        test_cross_region();
        test_illegal();
        test_reset_in_split();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_store_unit.md
Name: rv32i_store_unit

Overview:
Registered, parametrised store path between the rv32i execute stage and the byte-lane data memories. It accepts one store per valid/ready handshake and decodes funct3 (SB/SH/SW). It selects the target among NUM_REGIONS data memory regions and drives per-region 4-bit byte write enables with lane-aligned write data. Unlike the previous generation, misaligned SH/SW are supported: a store crossing a word boundary is split into two sequential beats, and illegal stores raise a fault pulse instead of being silently dropped.

Parameters:
NUM_REGIONS, 2, number of byte-lane memory regions (1..8)
REGION_BASE, {32'h0000C000, 32'h00008000}, packed NUM_REGIONS x 32-bit region base addresses; region 0 in the LSBs
REGION_BITS, {8'd13, 8'd14}, packed NUM_REGIONS x 8-bit log2 byte size per region; region 0 in the LSBs

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  unit can accept a request this cycle
req_funct3  input  3  instruction bits 14:12
req_addr  input  32  byte address from the CPU
req_data  input  32  rs2 store data
mem_we  output  4*NUM_REGIONS  byte write enables; bits [4r+3:4r] belong to region r
mem_addr  output  32  word-aligned byte address of the current beat (low 2 bits = 0)
mem_wdata  output  32  lane-aligned write data; disabled lanes = 0
store_done  output  1  one-cycle pulse with the final beat of a legal store
store_fault  output  1  one-cycle pulse for an illegal store
busy  output  1  high while the unit is in state SPLIT

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, store_done=0, store_fault=0, busy=0, state=IDLE. req_ready is 0 while reset is high.
- Access size from funct3: 000 = 1 byte, 001 = 2 bytes, 010 = 4 bytes. Any other funct3 is illegal.
- Lane math:
  - o = req_addr[1:0]; lanes needed are o .. o+size-1.
  - Lanes below 4 form beat 0 at word address A = {req_addr[31:2], 2'b00}.
  - Lanes at 4 and above form beat 1 at A+4, on lane index minus 4.
  - Data is rotated left by 8*o bits and masked to the enabled lanes of each beat.
- Region match: region r matches address X when X >> REGION_BITS[r] == REGION_BASE[r] >> REGION_BITS[r]. The lowest-index matching region wins.
- Legality check, done at acceptance:
  - funct3 must be legal.
  - A must match a region.
  - If the store splits, A+4 must also match a region, which may be a different one.
  - If any check fails, the store is illegal: no enables are asserted at all, including for the first beat.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid with a legal, non-split store: the next cycle shows the beat-0 enables/address/data plus store_done. State stays IDLE.
    - On req_valid with a legal, split store: the next cycle shows beat 0 with store_done=0. State becomes SPLIT.
    - On req_valid with an illegal store: the next cycle shows mem_we=0, store_fault=1. State stays IDLE.
    - With no request: the next cycle shows mem_we=0.
  - SPLIT:
    - req_ready=0, busy=1; no new request is accepted.
    - The next cycle shows beat 1 at A+4 with store_done=1. State returns to IDLE.
- Latency and throughput:
  - Enables appear 1 cycle after acceptance and are asserted for exactly 1 cycle per beat.
  - Non-split stores sustain 1 per cycle back-to-back.
  - Split stores occupy 2 output cycles; the next acceptance is possible in the cycle the second beat is shown.
- Boundary conditions:
  - A store that ends exactly at lane 3 is not split; e.g. SH at o=2 or SW at o=0.
  - A split that crosses from one region into an adjacent region writes beat 0 to the first region and beat 1 to the second.
  - A split whose A+4 falls outside every region is faulted as a whole.
  - Address wrap: A=0xFFFFFFFC with a split wraps A+4 to 0 and is checked like any other address.
  - Reset asserted while in SPLIT abandons beat 1: outputs clear the next cycle and store_done does not pulse.
  - req_valid while req_ready=0 is ignored; the requester must hold its request.

Test Plan:
1. SW 0xDEADBEEF at 0x00008004 -> next cycle mem_we[3:0]=1111, mem_addr=0x00008004, mem_wdata=0xDEADBEEF, store_done=1.
2. SB 0x000000AB at 0x0000C003 -> mem_we[7:4]=1000, mem_wdata=0xAB000000, region 0 enables=0.
3. SH 0x00001234 at 0x00008003 -> beat 0: mem_we[3:0]=1000, addr 0x8000, data 0x34000000; beat 1: mem_we[3:0]=0001, addr 0x8004, data 0x00000012, store_done only on beat 1; req_ready=0 during beat 0.
4. SW 0x11223344 at 0x0000BFFE -> beat 0: region 0 enables 1100 at 0xBFFC, data 0x33440000; beat 1: region 1 enables 0011 at 0xC000, data 0x00001122.
5. Illegal cases (funct3=011 at 0x8000; SW at 0x00001000; SW at 0x0000DFFE splitting out of region 1) -> mem_we=0, store_fault=1, store_done=0 in each.
6. Reset asserted in the SPLIT cycle of scenario 3 -> next cycle all outputs 0, no beat 1, no store_done; the following SW is accepted normally.
